// File: rtl/rs_station_param.sv
// rtl/rs_station_param.sv - parametrised reservation station with CDB wakeup and oldest-ready issue
module rs_station_param #(
    parameter int DEPTH  = 16,
    parameter int N_CDB  = 2,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rdy,
    input  logic                      clr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OP_W-1:0]           in_op,
    input  logic [DATA_W-1:0]         in_a,
    input  logic [DATA_W-1:0]         in_pc,
    input  logic [TAG_W-1:0]          in_tag,
    input  logic                      in_pj,
    input  logic                      in_pk,
    input  logic [DATA_W-1:0]         in_vj,
    input  logic [DATA_W-1:0]         in_vk,
    input  logic [N_CDB-1:0]          cdb_valid,
    input  logic [N_CDB*TAG_W-1:0]    cdb_tag,
    input  logic [N_CDB*DATA_W-1:0]   cdb_value,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OP_W-1:0]           out_op,
    output logic [DATA_W-1:0]         out_vj,
    output logic [DATA_W-1:0]         out_vk,
    output logic [DATA_W-1:0]         out_a,
    output logic [DATA_W-1:0]         out_pc,
    output logic [TAG_W-1:0]          out_tag,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0]  valid_q, pj_q, pk_q;
    // older_q[i][j] = 1 means entry i was allocated before entry j
    logic [DEPTH-1:0]  older_q [DEPTH];
    logic [CW-1:0]     count_q;

    logic [OP_W-1:0]   op_q  [DEPTH];
    logic [DATA_W-1:0] a_q   [DEPTH];
    logic [DATA_W-1:0] pc_q  [DEPTH];
    logic [DATA_W-1:0] vj_q  [DEPTH];
    logic [DATA_W-1:0] vk_q  [DEPTH];
    logic [TAG_W-1:0]  tag_q [DEPTH];
    logic [TAG_W-1:0]  qj_q  [DEPTH];
    logic [TAG_W-1:0]  qk_q  [DEPTH];

    logic [DEPTH-1:0]  ready_vec, sel_vec;
    logic              blocked;
    logic              sel_any;
    logic [IW-1:0]     sel_idx, free_idx;
    logic              accept, issue_slot, do_issue;

    logic [DEPTH-1:0]  wj_hit, wk_hit;
    logic [DATA_W-1:0] wj_val [DEPTH];
    logic [DATA_W-1:0] wk_val [DEPTH];
    logic              bj_hit, bk_hit;
    logic [DATA_W-1:0] bj_val, bk_val;

    assign count      = count_q;
    assign in_ready   = rdy && !clr && (count_q != CW'(DEPTH));
    assign accept     = in_valid && in_ready;
    assign ready_vec  = valid_q & ~pj_q & ~pk_q;
    assign sel_any    = |ready_vec;
    assign issue_slot = rdy && !clr && (!out_valid || out_ready);
    assign do_issue   = issue_slot && sel_any;

    // An entry is selected when no other ready entry is older than it
    always_comb begin
        sel_vec = '0;
        blocked = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (ready_vec[j] && older_q[j][i]) begin
                    blocked = 1'b1;
                end
            end
            sel_vec[i] = ready_vec[i] && !blocked;
        end
    end

    always_comb begin
        sel_idx  = '0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (sel_vec[i]) begin
                sel_idx = IW'(i);
            end
            if (!valid_q[i]) begin
                free_idx = IW'(i);
            end
        end
    end

    // Channels scanned from the top down so the lowest matching channel wins
    always_comb begin
        wj_hit = '0;
        wk_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wj_val[i] = '0;
            wk_val[i] = '0;
            for (int c = N_CDB - 1; c >= 0; c--) begin
                if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == qj_q[i]) begin
                    wj_hit[i] = 1'b1;
                    wj_val[i] = cdb_value[c*DATA_W +: DATA_W];
                end
                if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == qk_q[i]) begin
                    wk_hit[i] = 1'b1;
                    wk_val[i] = cdb_value[c*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        bj_hit = 1'b0;
        bk_hit = 1'b0;
        bj_val = '0;
        bk_val = '0;
        for (int c = N_CDB - 1; c >= 0; c--) begin
            if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == in_vj[TAG_W-1:0]) begin
                bj_hit = 1'b1;
                bj_val = cdb_value[c*DATA_W +: DATA_W];
            end
            if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == in_vk[TAG_W-1:0]) begin
                bk_hit = 1'b1;
                bk_val = cdb_value[c*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            pj_q      <= '0;
            pk_q      <= '0;
            count_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                older_q[i] <= '0;
            end
            out_valid <= 1'b0;
            out_op    <= '0;
            out_vj    <= '0;
            out_vk    <= '0;
            out_a     <= '0;
            out_pc    <= '0;
            out_tag   <= '0;
        end else if (clr) begin
            valid_q   <= '0;
            pj_q      <= '0;
            pk_q      <= '0;
            count_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                older_q[i] <= '0;
            end
            out_valid <= 1'b0;
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && pj_q[i] && wj_hit[i]) begin
                    pj_q[i] <= 1'b0;
                end
                if (valid_q[i] && pk_q[i] && wk_hit[i]) begin
                    pk_q[i] <= 1'b0;
                end
            end
            if (issue_slot) begin
                out_valid <= sel_any;
                if (sel_any) begin
                    valid_q[sel_idx] <= 1'b0;
                    out_op  <= op_q[sel_idx];
                    out_vj  <= vj_q[sel_idx];
                    out_vk  <= vk_q[sel_idx];
                    out_a   <= a_q[sel_idx];
                    out_pc  <= pc_q[sel_idx];
                    out_tag <= tag_q[sel_idx];
                end
            end
            if (accept) begin
                valid_q[free_idx] <= 1'b1;
                pj_q[free_idx]    <= in_pj && !bj_hit;
                pk_q[free_idx]    <= in_pk && !bk_hit;
                older_q[free_idx] <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (valid_q[j] && !(do_issue && sel_idx == IW'(j))) begin
                        older_q[j][free_idx] <= 1'b1;
                    end
                end
            end
            case ({accept, do_issue})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked by valid_q/pj_q/pk_q
    always_ff @(posedge clk) begin
        if (rdy && !clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && pj_q[i] && wj_hit[i]) begin
                    vj_q[i] <= wj_val[i];
                end
                if (valid_q[i] && pk_q[i] && wk_hit[i]) begin
                    vk_q[i] <= wk_val[i];
                end
            end
            if (accept) begin
                op_q[free_idx]  <= in_op;
                a_q[free_idx]   <= in_a;
                pc_q[free_idx]  <= in_pc;
                tag_q[free_idx] <= in_tag;
                qj_q[free_idx]  <= in_vj[TAG_W-1:0];
                qk_q[free_idx]  <= in_vk[TAG_W-1:0];
                vj_q[free_idx]  <= (in_pj && bj_hit) ? bj_val : in_vj;
                vk_q[free_idx]  <= (in_pk && bk_hit) ? bk_val : in_vk;
            end
        end
    end

endmodule

// File: tb/tb_rs_station_param.sv
// tb/tb_rs_station_param.sv - self-checking bench for rs_station_param
module tb_rs_station_param;

    localparam int DEPTH  = 4;
    localparam int N_CDB  = 2;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
    localparam int OP_W   = 6;
    localparam int CW     = $clog2(DEPTH + 1);

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    rdy = 1'b1;
    logic                    clr = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [OP_W-1:0]         in_op = '0;
    logic [DATA_W-1:0]       in_a = '0, in_pc = '0, in_vj = '0, in_vk = '0;
    logic [TAG_W-1:0]        in_tag = '0;
    logic                    in_pj = 1'b0, in_pk = 1'b0;
    logic [N_CDB-1:0]        cdb_valid = '0;
    logic [N_CDB*TAG_W-1:0]  cdb_tag = '0;
    logic [N_CDB*DATA_W-1:0] cdb_value = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [OP_W-1:0]         out_op;
    logic [DATA_W-1:0]       out_vj, out_vk, out_a, out_pc;
    logic [TAG_W-1:0]        out_tag;
    logic [CW-1:0]           count;

    int n_tests = 0;
    int n_fail  = 0;

    rs_station_param #(.DEPTH(DEPTH), .N_CDB(N_CDB), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_pc(in_pc),
        .in_tag(in_tag), .in_pj(in_pj), .in_pk(in_pk), .in_vj(in_vj), .in_vk(in_vk),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_vj(out_vj),
        .out_vk(out_vk), .out_a(out_a), .out_pc(out_pc), .out_tag(out_tag), .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: entries kept in a queue in allocation order, so the oldest ready is the first ready
    typedef struct {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a, pc, vj, vk;
        logic [TAG_W-1:0]  tag, qj, qk;
        bit                pj, pk;
    } ent_t;

    ent_t mq[$];
    bit   m_ov;
    ent_t m_out;

    function automatic bit cdb_hit(input logic [TAG_W-1:0] t, output logic [DATA_W-1:0] v);
        for (int c = 0; c < N_CDB; c++) begin
            if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == t) begin
                v = cdb_value[c*DATA_W +: DATA_W];
                return 1'b1;
            end
        end
        v = '0;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ov  = 1'b0;
        m_out = '{default: 0};
    endtask

    task automatic model_step();
        ent_t e;
        logic [DATA_W-1:0] v;
        int idx;
        bit acc;
        if (clr) begin
            mq.delete();
            m_ov = 1'b0;
            return;
        end
        if (!rdy) return;
        acc = in_valid && (mq.size() < DEPTH);
        if (!m_ov || out_ready) begin
            idx = -1;
            foreach (mq[i]) if (idx < 0 && !mq[i].pj && !mq[i].pk) idx = i;
            if (idx >= 0) begin
                m_out = mq[idx];
                m_ov  = 1'b1;
                mq.delete(idx);
            end else begin
                m_ov = 1'b0;
            end
        end
        foreach (mq[i]) begin
            e = mq[i];
            if (e.pj && cdb_hit(e.qj, v)) begin e.pj = 1'b0; e.vj = v; end
            if (e.pk && cdb_hit(e.qk, v)) begin e.pk = 1'b0; e.vk = v; end
            mq[i] = e;
        end
        if (acc) begin
            e.op = in_op; e.a = in_a; e.pc = in_pc; e.tag = in_tag;
            e.pj = in_pj; e.pk = in_pk; e.vj = in_vj; e.vk = in_vk;
            e.qj = in_vj[TAG_W-1:0]; e.qk = in_vk[TAG_W-1:0];
            if (e.pj && cdb_hit(e.qj, v)) begin e.pj = 1'b0; e.vj = v; end
            if (e.pk && cdb_hit(e.qk, v)) begin e.pk = 1'b0; e.vk = v; end
            mq.push_back(e);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; cdb_valid = '0; clr = 1'b0; rdy = 1'b1;
    endtask

    task automatic drive_in(input int op, input int tag, input bit pj, input int vj, input bit pk, input int vk);
        in_valid = 1'b1;
        in_op = OP_W'(op); in_tag = TAG_W'(tag);
        in_a = DATA_W'($urandom); in_pc = DATA_W'($urandom);
        in_pj = pj; in_vj = DATA_W'(vj); in_pk = pk; in_vk = DATA_W'(vk);
    endtask

    task automatic drive_cdb(input int ch, input int tag, input int val);
        cdb_valid[ch] = 1'b1;
        cdb_tag[ch*TAG_W +: TAG_W] = TAG_W'(tag);
        cdb_value[ch*DATA_W +: DATA_W] = DATA_W'(val);
    endtask

    task automatic test_reset();
        idle(); out_ready = 1'b0; rst_n = 1'b0;
        #1;
        n_tests++;
        if (count !== 0 || out_valid !== 1'b0 || out_tag !== 0 || out_vj !== 0 || out_op !== 0) begin
            n_fail++;
            $display("FAIL reset_initial: count=%0d out_valid=%b out_tag=%0d out_vj=%h, need 0/0/0/0", count, out_valid, out_tag, out_vj);
        end
        @(negedge clk); rst_n = 1'b1; model_reset();
        for (int i = 0; i < 3; i++) begin drive_in(1, i + 1, 1, 7, 0, 0); step(); end
        drive_in(2, 4, 0, 'h44, 0, 0); step();
        idle(); step();
        n_tests++;
        if (count !== 3 || out_valid !== 1'b1 || out_tag !== 4) begin
            n_fail++;
            $display("FAIL reset_prefill: count=%0d out_valid=%b out_tag=%0d, need 3/1/4", count, out_valid, out_tag);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (count !== 0 || out_valid !== 1'b0 || out_tag !== 0) begin
            n_fail++;
            $display("FAIL reset_async: count=%0d out_valid=%b out_tag=%0d, need 0/0/0", count, out_valid, out_tag);
        end
        rst_n = 1'b1; model_reset();
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: in_ready=%b, need 1", in_ready);
        end
    endtask

    task automatic test_full();
        idle(); out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin drive_in(3, i + 1, 1, 7, 0, 0); step(); end
        n_tests++;
        if (in_ready !== 1'b0 || count !== CW'(DEPTH)) begin
            n_fail++;
            $display("FAIL full_state: in_ready=%b count=%0d, need 0/%0d", in_ready, count, DEPTH);
        end
        drive_in(3, 9, 0, 1, 0, 0); step();
        n_tests++;
        if (count !== CW'(DEPTH) || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_no_accept: count=%0d out_valid=%b, need %0d/0", count, out_valid, DEPTH);
        end
        idle(); drive_cdb(1, 7, 'habc); step();
        n_tests++;
        if (out_valid !== 1'b0 || count !== CW'(DEPTH)) begin
            n_fail++;
            $display("FAIL full_wake_latency: out_valid=%b count=%0d, need 0/%0d", out_valid, count, DEPTH);
        end
        idle(); step();
        n_tests++;
        if (out_valid !== 1'b1 || count !== CW'(DEPTH - 1) || in_ready !== 1'b1 || out_tag !== 1 || out_vj !== 'habc) begin
            n_fail++;
            $display("FAIL full_issue: out_valid=%b count=%0d in_ready=%b out_tag=%0d out_vj=%h, need 1/3/1/1/abc",
                     out_valid, count, in_ready, out_tag, out_vj);
        end
        for (int i = 0; i < DEPTH; i++) step();
        n_tests++;
        if (count !== 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drain: count=%0d out_valid=%b, need 0/0", count, out_valid);
        end
    endtask

    task automatic test_oldest();
        logic [TAG_W-1:0]  got_tag[$];
        logic [DATA_W-1:0] got_vj[$];
        logic [TAG_W-1:0]  exp_tag[3];
        logic [DATA_W-1:0] exp_vj[3];
        exp_tag = '{4'd9, 4'd10, 4'd11};
        exp_vj  = '{32'h11, 32'h55, 32'h55};
        idle(); out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            idle();
            case (i)
                0: drive_in(1, 10, 1, 3, 0, 0);
                1: drive_in(1, 9, 0, 'h11, 0, 0);
                2: drive_in(1, 11, 1, 3, 0, 0);
                3: drive_cdb(0, 3, 'h55);
                default: ;
            endcase
            step();
            if (out_valid === 1'b1) begin got_tag.push_back(out_tag); got_vj.push_back(out_vj); end
        end
        idle();
        n_tests++;
        if (got_tag.size() != 3) begin
            n_fail++;
            $display("FAIL oldest_count: issued=%0d, need 3", got_tag.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (got_tag[k] !== exp_tag[k] || got_vj[k] !== exp_vj[k]) begin
                    n_fail++;
                    $display("FAIL oldest_order[%0d]: tag=%0d vj=%h, need tag=%0d vj=%h", k, got_tag[k], got_vj[k], exp_tag[k], exp_vj[k]);
                end
            end
        end
    endtask

    task automatic test_bypass();
        idle(); out_ready = 1'b1;
        drive_in(5, 6, 0, 1, 1, 5); drive_cdb(0, 5, 'h1234); step();
        idle(); drive_cdb(0, 5, 'hdead); step();
        n_tests++;
        if (out_valid !== 1'b1 || out_vk !== 'h1234 || out_tag !== 6) begin
            n_fail++;
            $display("FAIL bypass_value: out_valid=%b out_vk=%h out_tag=%0d, need 1/1234/6", out_valid, out_vk, out_tag);
        end
        idle(); drive_cdb(0, 5, 'hbeef); step();
        idle();
        n_tests++;
        if (out_valid !== 1'b0 || count !== 0) begin
            n_fail++;
            $display("FAIL bypass_late_cdb: out_valid=%b count=%0d, need 0/0", out_valid, count);
        end
    endtask

    task automatic test_backpressure();
        logic [TAG_W-1:0]  s_tag;
        logic [DATA_W-1:0] s_vj, s_pc;
        logic [CW-1:0]     s_cnt;
        idle(); out_ready = 1'b0;
        drive_in(7, 1, 0, 'h100, 0, 0); step();
        drive_in(7, 2, 1, 6, 0, 0); step();
        drive_in(7, 3, 1, 6, 0, 0); step();
        idle();
        s_tag = out_tag; s_vj = out_vj; s_pc = out_pc; s_cnt = count;
        n_tests++;
        if (out_valid !== 1'b1 || out_tag !== 1 || count !== 2) begin
            n_fail++;
            $display("FAIL bp_first: out_valid=%b out_tag=%0d count=%0d, need 1/1/2", out_valid, out_tag, count);
        end
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i == 1) drive_cdb(0, 6, 'h66);
            step();
            n_tests++;
            if (out_valid !== 1'b1 || out_tag !== s_tag || out_vj !== s_vj || out_pc !== s_pc || count !== s_cnt) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: out_valid=%b tag=%0d vj=%h count=%0d, need 1/%0d/%h/%0d",
                         i, out_valid, out_tag, out_vj, count, s_tag, s_vj, s_cnt);
            end
        end
        idle(); out_ready = 1'b1; step();
        n_tests++;
        if (out_valid !== 1'b1 || out_tag !== 2 || out_vj !== 'h66 || count !== 1) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b out_tag=%0d out_vj=%h count=%0d, need 1/2/66/1", out_valid, out_tag, out_vj, count);
        end
        step(); step();
    endtask

    task automatic test_flush_stall();
        logic [TAG_W-1:0] s_tag;
        idle(); out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin drive_in(4, i + 5, 1, 8, 0, 0); step(); end
        drive_in(4, 12, 0, 'h9, 0, 0); step();
        idle(); step();
        s_tag = out_tag;
        for (int i = 0; i < 3; i++) begin
            rdy = 1'b0; drive_cdb(0, 8, 'h88); drive_in(4, 13, 0, 1, 0, 0); out_ready = 1'b1;
            step();
            n_tests++;
            if (count !== 3 || out_valid !== 1'b1 || out_tag !== s_tag || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall[%0d]: count=%0d out_valid=%b out_tag=%0d in_ready=%b, need 3/1/%0d/0",
                         i, count, out_valid, out_tag, in_ready, s_tag);
            end
        end
        idle(); clr = 1'b1; drive_in(4, 14, 0, 1, 0, 0); step();
        n_tests++;
        if (count !== 0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: count=%0d out_valid=%b in_ready=%b, need 0/0/0", count, out_valid, in_ready);
        end
        idle(); #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_in_ready: in_ready=%b, need 1", in_ready);
        end
        step();
        n_tests++;
        if (count !== 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_empty: count=%0d out_valid=%b, need 0/0", count, out_valid);
        end
    endtask

    task automatic test_random();
        bit exp_ir;
        for (int cyc = 0; cyc < 800; cyc++) begin
            idle();
            rdy       = ($urandom_range(0, 9) != 0);
            clr       = ($urandom_range(0, 59) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 1) == 1)
                drive_in($urandom, $urandom, $urandom_range(0, 1), $urandom & 32'hfffffff3, $urandom_range(0, 1), $urandom & 32'hfffffff3);
            for (int c = 0; c < N_CDB; c++)
                if ($urandom_range(0, 9) < 4) drive_cdb(c, $urandom_range(0, 3), $urandom);
            step();
            exp_ir = rdy && !clr && (mq.size() != DEPTH);
            n_tests++;
            if (count !== CW'(mq.size()) || in_ready !== exp_ir || out_valid !== m_ov) begin
                n_fail++;
                $display("FAIL rand_state cyc%0d: count=%0d in_ready=%b out_valid=%b, need %0d/%b/%b",
                         cyc, count, in_ready, out_valid, mq.size(), exp_ir, m_ov);
            end
            if (m_ov) begin
                n_tests++;
                if ({out_op, out_vj, out_vk, out_a, out_pc, out_tag} !==
                    {m_out.op, m_out.vj, m_out.vk, m_out.a, m_out.pc, m_out.tag}) begin
                    n_fail++;
                    $display("FAIL rand_out cyc%0d: tag=%0d vj=%h vk=%h, need tag=%0d vj=%h vk=%h",
                             cyc, out_tag, out_vj, out_vk, m_out.tag, m_out.vj, m_out.vk);
                end
            end
        end
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full();
        test_oldest();
        test_bypass();
        test_backpressure();
        test_flush_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
